// File: rtl/if_stage_if.sv
// Fetch-stage bundle: inst SRAM port plus the fs->ds valid/allowin link.
// master = fetch stage; slave = SRAM and decode side.
interface if_stage_if;
  logic        inst_sram_en;
  logic        inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        ds_allowin;
  logic        br_taken;
  logic [31:0] br_target;
  logic        fs_to_ds_valid;
  logic [31:0] fs_pc;
  logic [31:0] fs_inst;

  modport master (
    output inst_sram_en, inst_sram_we,
    output inst_sram_addr, inst_sram_wdata,
    input  inst_sram_rdata,
    input  ds_allowin, br_taken, br_target,
    output fs_to_ds_valid, fs_pc, fs_inst
  );

  modport slave (
    input  inst_sram_en, inst_sram_we,
    input  inst_sram_addr, inst_sram_wdata,
    output inst_sram_rdata,
    output ds_allowin, br_taken, br_target,
    input  fs_to_ds_valid, fs_pc, fs_inst
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch: owns the PC, drives the 1-cycle inst SRAM, buffers
// on decode stall, squashes on redirect. Ports: clk, reset, bus (master).
module if_stage #(
  parameter logic [31:0] PC_RESET = 32'h1c00_0000
) (
  input  logic        clk,
  input  logic        reset,
  if_stage_if.master  bus
);

  logic        fs_valid;
  logic [31:0] fs_pc_r;
  logic [31:0] inst_buf;
  logic        inst_buf_valid;
  logic        br_pend;
  logic [31:0] br_pend_tgt;

  logic        fs_allowin;
  logic [31:0] nextpc;

  assign fs_allowin = !fs_valid || bus.ds_allowin;

  // A live redirect beats an older pending one.
  assign nextpc = bus.br_taken ? bus.br_target :
                  br_pend      ? br_pend_tgt   :
                                 fs_pc_r + 32'd4;

  assign bus.inst_sram_en    = !reset && fs_allowin;
  assign bus.inst_sram_we    = 1'b0;
  assign bus.inst_sram_addr  = nextpc;
  assign bus.inst_sram_wdata = 32'd0;

  // Wrong-path instruction dies the same cycle decode redirects.
  assign bus.fs_to_ds_valid = fs_valid && !bus.br_taken;
  assign bus.fs_pc          = fs_pc_r;
  assign bus.fs_inst        = inst_buf_valid ? inst_buf
                                             : bus.inst_sram_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      fs_valid       <= 1'b0;
      fs_pc_r        <= PC_RESET - 32'd4;
      inst_buf       <= 32'd0;
      inst_buf_valid <= 1'b0;
      br_pend        <= 1'b0;
      br_pend_tgt    <= 32'd0;
    end else if (fs_allowin) begin
      fs_valid       <= 1'b1;
      fs_pc_r        <= nextpc;
      br_pend        <= 1'b0;
      inst_buf_valid <= 1'b0;
    end else if (bus.br_taken) begin
      // Stalled redirect: drop the held instruction, fetch target next.
      fs_valid       <= 1'b0;
      inst_buf_valid <= 1'b0;
      br_pend        <= 1'b1;
      br_pend_tgt    <= bus.br_target;
    end else if (!inst_buf_valid) begin
      // SRAM output is only trustworthy on the first stall cycle.
      inst_buf       <= bus.inst_sram_rdata;
      inst_buf_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a 1-cycle SRAM model.
// Expected values are hand-computed per step.
module tb_if_stage;
  logic clk = 1'b0;
  logic reset;
  logic garbage;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  if_stage_if bus();

  if_stage u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always @(posedge clk) begin
    if (garbage)
      bus.inst_sram_rdata <= 32'hdead_beef;
    else if (bus.inst_sram_en)
      bus.inst_sram_rdata <= 32'h0280_0400
                           + {24'd0, bus.inst_sram_addr[7:0]};
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic al, input logic bt,
                       input logic [31:0] tgt);
    bus.ds_allowin = al;
    bus.br_taken   = bt;
    bus.br_target  = tgt;
    #1;
  endtask

  initial begin
    reset   = 1'b1;
    garbage = 1'b0;
    bus.ds_allowin = 1'b1;
    bus.br_taken   = 1'b0;
    bus.br_target  = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, bus.fs_to_ds_valid}, 32'd0);
    chk("rst_en", {31'd0, bus.inst_sram_en}, 32'd0);
    chk("rst_addr", bus.inst_sram_addr, 32'h1c00_0000);
    chk("rst_we", {31'd0, bus.inst_sram_we}, 32'd0);

    reset = 1'b0;
    drive(1'b1, 1'b0, 32'd0);
    chk("c0_en", {31'd0, bus.inst_sram_en}, 32'd1);
    chk("c0_addr", bus.inst_sram_addr, 32'h1c00_0000);
    chk("c0_valid", {31'd0, bus.fs_to_ds_valid}, 32'd0);

    tick();
    chk("c1_valid", {31'd0, bus.fs_to_ds_valid}, 32'd1);
    chk("c1_pc", bus.fs_pc, 32'h1c00_0000);
    chk("c1_inst", bus.fs_inst, 32'h0280_0400);
    chk("c1_addr", bus.inst_sram_addr, 32'h1c00_0004);

    tick();
    chk("c2_pc", bus.fs_pc, 32'h1c00_0004);
    chk("c2_inst", bus.fs_inst, 32'h0280_0404);
    chk("c2_addr", bus.inst_sram_addr, 32'h1c00_0008);

    tick();
    drive(1'b0, 1'b0, 32'd0);
    chk("c3_pc", bus.fs_pc, 32'h1c00_0008);
    chk("c3_inst", bus.fs_inst, 32'h0280_0408);
    chk("c3_stall_en", {31'd0, bus.inst_sram_en}, 32'd0);

    tick();
    garbage = 1'b1;
    drive(1'b0, 1'b0, 32'd0);
    chk("c4_inst", bus.fs_inst, 32'h0280_0408);
    chk("c4_en", {31'd0, bus.inst_sram_en}, 32'd0);
    chk("c4_valid", {31'd0, bus.fs_to_ds_valid}, 32'd1);

    tick();
    chk("c5_inst", bus.fs_inst, 32'h0280_0408);
    chk("c5_pc", bus.fs_pc, 32'h1c00_0008);

    tick();
    garbage = 1'b0;
    drive(1'b1, 1'b0, 32'd0);
    chk("c6_inst", bus.fs_inst, 32'h0280_0408);
    chk("c6_en", {31'd0, bus.inst_sram_en}, 32'd1);
    chk("c6_addr", bus.inst_sram_addr, 32'h1c00_000c);

    tick();
    chk("c7_pc", bus.fs_pc, 32'h1c00_000c);
    chk("c7_inst", bus.fs_inst, 32'h0280_040c);
    drive(1'b1, 1'b1, 32'h1c00_0100);
    chk("c7_br_valid", {31'd0, bus.fs_to_ds_valid}, 32'd0);
    chk("c7_br_en", {31'd0, bus.inst_sram_en}, 32'd1);
    chk("c7_br_addr", bus.inst_sram_addr, 32'h1c00_0100);

    tick();
    drive(1'b0, 1'b0, 32'd0);
    chk("c8_valid", {31'd0, bus.fs_to_ds_valid}, 32'd1);
    chk("c8_pc", bus.fs_pc, 32'h1c00_0100);
    chk("c8_inst", bus.fs_inst, 32'h0280_0400);
    chk("c8_en", {31'd0, bus.inst_sram_en}, 32'd0);

    tick();
    drive(1'b0, 1'b1, 32'h1c00_0200);
    chk("c9_en", {31'd0, bus.inst_sram_en}, 32'd0);
    chk("c9_valid", {31'd0, bus.fs_to_ds_valid}, 32'd0);

    tick();
    drive(1'b0, 1'b0, 32'd0);
    chk("c10_valid", {31'd0, bus.fs_to_ds_valid}, 32'd0);
    chk("c10_en", {31'd0, bus.inst_sram_en}, 32'd1);
    chk("c10_addr", bus.inst_sram_addr, 32'h1c00_0200);

    tick();
    drive(1'b0, 1'b0, 32'd0);
    chk("c11_pc", bus.fs_pc, 32'h1c00_0200);
    chk("c11_valid", {31'd0, bus.fs_to_ds_valid}, 32'd1);
    chk("c11_en", {31'd0, bus.inst_sram_en}, 32'd0);

    tick();
    drive(1'b0, 1'b1, 32'h1c00_0300);
    chk("c12_en", {31'd0, bus.inst_sram_en}, 32'd0);

    tick();
    drive(1'b0, 1'b1, 32'h1c00_0400);
    chk("c13_en", {31'd0, bus.inst_sram_en}, 32'd1);
    chk("c13_addr", bus.inst_sram_addr, 32'h1c00_0400);
    chk("c13_valid", {31'd0, bus.fs_to_ds_valid}, 32'd0);

    tick();
    drive(1'b0, 1'b0, 32'd0);
    chk("c14_pc", bus.fs_pc, 32'h1c00_0400);
    chk("c14_valid", {31'd0, bus.fs_to_ds_valid}, 32'd1);

    tick();
    drive(1'b0, 1'b1, 32'h1c00_0500);
    chk("c15_en", {31'd0, bus.inst_sram_en}, 32'd0);

    tick();
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'd0);
    chk("c16_pend_addr", bus.inst_sram_addr, 32'h1c00_0500);
    chk("c16_rst_en", {31'd0, bus.inst_sram_en}, 32'd0);

    tick();
    reset = 1'b0;
    drive(1'b1, 1'b0, 32'd0);
    chk("c17_valid", {31'd0, bus.fs_to_ds_valid}, 32'd0);
    chk("c17_en", {31'd0, bus.inst_sram_en}, 32'd1);
    chk("c17_addr", bus.inst_sram_addr, 32'h1c00_0000);

    tick();
    chk("c18_valid", {31'd0, bus.fs_to_ds_valid}, 32'd1);
    chk("c18_pc", bus.fs_pc, 32'h1c00_0000);
    chk("c18_inst", bus.fs_inst, 32'h0280_0400);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage placed directly upstream of the decode stage in the pipelined LoongArch core.
- Owns the PC and generates next-PC: sequential +4, or a redirect from decode on a taken branch.
- Drives the synchronous inst SRAM (1-cycle read latency) and hands {pc, inst} to decode over a valid/allowin handshake.
- Buffers the fetched instruction while decode stalls, and squashes wrong-path fetches on redirect.

Parameters:
- PC_RESET, 32'h1c00_0000, address of the first instruction fetched after reset.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- inst_sram_en  output  1  read request; the address is sampled this cycle and data returns next cycle
- inst_sram_we  output  1  tied 0
- inst_sram_addr  output  32  fetch address (equals nextpc)
- inst_sram_wdata  output  32  tied 0
- inst_sram_rdata  input  32  read data, valid the cycle after the request
- ds_allowin  input  1  decode can accept an instruction this cycle
- br_taken  input  1  one-cycle redirect pulse from decode
- br_target  input  32  redirect address, qualified by br_taken
- fs_to_ds_valid  output  1  {fs_pc, fs_inst} is valid for decode
- fs_pc  output  32  PC of the instruction being presented
- fs_inst  output  32  instruction word being presented

Behaviour:
- Interface: clock clk; reset is synchronous, active-high.
- Internal state:
  - fs_valid
  - fs_pc_r
  - inst_buf[31:0], inst_buf_valid
  - br_pend, br_pend_tgt[31:0]
- Reset values:
  - fs_valid=0, fs_pc_r=PC_RESET-4, inst_buf_valid=0, br_pend=0.
  - Outputs: fs_to_ds_valid=0, inst_sram_en=0, inst_sram_addr=PC_RESET.
- Combinational signals:
  - fs_allowin = !fs_valid || ds_allowin. The stage's ready_go is always 1.
  - nextpc = br_taken ? br_target : br_pend ? br_pend_tgt : fs_pc_r+4. Arithmetic is 32-bit and wraps modulo 2^32.
  - inst_sram_addr = nextpc.
  - inst_sram_en = !reset && fs_allowin.
  - fs_to_ds_valid = fs_valid && !br_taken. The current instruction is squashed in the same cycle as a redirect.
  - fs_inst = inst_buf_valid ? inst_buf : inst_sram_rdata.
  - fs_pc = fs_pc_r.
- Issue cycle (inst_sram_en=1), applied at the next clock edge:
  - fs_valid <= 1
  - fs_pc_r <= nextpc
  - br_pend <= 0
  - inst_buf_valid <= 0
- Latency:
  - First request is issued in the first cycle with reset low.
  - First fs_to_ds_valid is in the following cycle, with fs_pc=PC_RESET.
  - Steady-state throughput is 1 instruction per cycle while ds_allowin=1.
- Stall (fs_valid && !ds_allowin && !br_taken):
  - No request; fs_pc_r holds.
  - On the first stall cycle, if !inst_buf_valid: inst_buf <= inst_sram_rdata and inst_buf_valid <= 1.
  - The buffer holds until the issue cycle clears it.
- Redirect while issuing (br_taken && fs_allowin):
  - The SRAM is requested at br_target; fs_pc_r <= br_target.
  - The old fs instruction is never presented as valid.
- Redirect while stalled (br_taken && !fs_allowin):
  - fs_valid <= 0, inst_buf_valid <= 0, br_pend <= 1, br_pend_tgt <= br_target.
  - The next cycle has fs_allowin=1 and issues at br_pend_tgt.
- Redirect with br_pend already set: the newer br_taken overrides br_pend_tgt.
- Reset mid-operation:
  - All state returns to reset values on the next edge.
  - Any pending redirect or buffered instruction is discarded.
  - An SRAM response arriving after reset is ignored.
- Misaligned br_target is passed through unchecked; decode owns exception detection.

Test Plan:
- Reset release, ds_allowin=1, SRAM returns 32'h0280_0400+addr[7:0] -> requests at 1c000000, 1c000004, 1c000008 in consecutive cycles; fs_to_ds_valid=1 one cycle after each request, with the matching fs_pc/fs_inst.
- Hold ds_allowin=0 for 3 cycles while fs_pc=1c000008, with SRAM rdata changed to garbage after the first stall cycle -> inst_sram_en=0; fs_inst stays the word for 1c000008; 1c00000c is requested the cycle ds_allowin returns to 1.
- br_taken=1, br_target=1c000100 with ds_allowin=1 -> fs_to_ds_valid=0 that cycle; SRAM request at 1c000100; next cycle fs_pc=1c000100, valid.
- br_taken=1, br_target=1c000200 during a stall -> no request that cycle; the next cycle requests 1c000200; the stalled instruction is never delivered.
- Two redirects, to 1c000300 then 1c000400, in consecutive stalled cycles -> the first fetch after the stall is 1c000400.
- Assert reset for 1 cycle mid-stream with br_pend set -> fs_to_ds_valid=0 next cycle; the first request after reset is at 1c000000.
